// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the shared UART arbiter.
// The arbiter uses the slave modport; producers and the uart_tx side use the master modport.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   req_data;
  logic [2*NREQ-1:0]    req_len;
  logic [NREQ-1:0]      ack;
  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic [7:0]           tx_sdata;
  logic                 tx_start;
  logic                 tx_busy;

  modport slave (
    input  req, req_data, req_len, tx_busy,
    output ack, grant_id, busy, tx_sdata, tx_start
  );

  modport master (
    output req, req_data, req_len, tx_busy,
    input  ack, grant_id, busy, tx_sdata, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ requesters.
// Each granted 1-4 byte word is sent LSB first, and the owner gets an ack when its last byte has left.
module uart_tx_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rstn,
  uart_tx_arbiter_if.slave  bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic              busy_q, busy_d;
  logic [7:0]        sdata_q, sdata_d;
  logic              start_q, start_d;
  logic [31:0]       buf_q, buf_d;
  logic [1:0]        cnt_q, cnt_d;

  logic [GW-1:0]     win;
  int                pick_idx;
  logic              go;

  // Scan from lowest to highest priority so the last hit is the first index after last_q.
  always_comb begin
    win      = last_q;
    pick_idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      pick_idx = int'(last_q) + k;
      if (pick_idx >= NREQ) pick_idx = pick_idx - NREQ;
      if (bus.req[pick_idx]) win = GW'(pick_idx);
    end
  end

  assign go = (state_q == IDLE) && (|bus.req) && !bus.tx_busy;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ack_q   <= '0;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);
      busy_q  <= 1'b0;
      sdata_q <= '0;
      start_q <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      sdata_q <= sdata_d;
      start_q <= start_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = SEND;
      SEND:    state_d = WAIT_HI;
      WAIT_HI: if (bus.tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!bus.tx_busy) state_d = (cnt_q != 2'd0) ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d   = '0;
    start_d = 1'b0;
    grant_d = grant_q;
    last_d  = last_q;
    busy_d  = busy_q;
    sdata_d = sdata_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          grant_d = win;
          last_d  = win;
          busy_d  = 1'b1;
          buf_d   = bus.req_data[32*win +: 32];
          cnt_d   = bus.req_len[2*win +: 2];
          sdata_d = bus.req_data[32*win +: 8];
          start_d = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (cnt_q != 2'd0) begin
            cnt_d   = cnt_q - 2'd1;
            buf_d   = buf_q >> 8;
            sdata_d = buf_q[15:8];
            start_d = 1'b1;
          end else begin
            ack_d[grant_q] = 1'b1;
            busy_d         = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.tx_sdata = sdata_q;
  assign bus.tx_start = start_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 2-requester instance for the data path and
// a 3-requester instance for round-robin order, each with a simple uart_tx busy model.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.NREQ(2)) ia ();
  uart_tx_arbiter_if #(.NREQ(3)) ib ();

  uart_tx_arbiter #(.NREQ(2)) dut_a (.clk(clk), .rstn(rstn), .bus(ia.slave));
  uart_tx_arbiter #(.NREQ(3)) dut_b (.clk(clk), .rstn(rstn), .bus(ib.slave));

  // uart_tx model: busy rises the cycle after tx_start and stays high 20 cycles; not reset.
  int   bcnt_a = 0;
  int   bcnt_b = 0;
  logic ext_busy_a = 1'b0;
  always @(posedge clk) begin
    if (ia.tx_start) bcnt_a <= 20;
    else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
    if (ib.tx_start) bcnt_b <= 20;
    else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
  end
  assign ia.tx_busy = (bcnt_a != 0) || ext_busy_a;
  assign ib.tx_busy = (bcnt_b != 0);

  logic [7:0] bytes_a[$];
  int         starts_a[$];
  int         width_err_a = 0;
  logic       prev_start_a = 1'b0;
  logic       prev_busy_a = 1'b0;
  int         last_fall_a = 0;
  int         ack_cnt_a[2];
  int         ack_cyc_a = 0;
  int         fall_at_ack_a = 0;
  logic [1:0] last_ack_a = '0;

  logic [7:0] bytes_b[$];
  int         ack_cnt_b[3];
  logic [2:0] last_ack_b = '0;
  logic [1:0] grant_at_ack_b = '0;

  always @(negedge clk) begin
    if (ia.tx_start) begin
      bytes_a.push_back(ia.tx_sdata);
      starts_a.push_back(cyc);
      if (prev_start_a) width_err_a++;
    end
    prev_start_a = ia.tx_start;
    if (prev_busy_a && !ia.tx_busy) last_fall_a = cyc;
    prev_busy_a = ia.tx_busy;
    if (ia.ack != 0) begin
      for (int i = 0; i < 2; i++) if (ia.ack[i]) ack_cnt_a[i]++;
      ack_cyc_a = cyc;
      fall_at_ack_a = last_fall_a;
      last_ack_a = ia.ack;
    end
    if (ib.tx_start) bytes_b.push_back(ib.tx_sdata);
    if (ib.ack != 0) begin
      for (int i = 0; i < 3; i++) if (ib.ack[i]) ack_cnt_b[i]++;
      last_ack_b = ib.ack;
      grant_at_ack_b = ib.grant_id;
    end
  end

  task automatic clear_a();
    bytes_a.delete();
    starts_a.delete();
    width_err_a = 0;
    ack_cnt_a[0] = 0;
    ack_cnt_a[1] = 0;
  endtask

  task automatic wait_ack_a(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ia.ack != 0) begin ok = 1'b1; break; end
    end
    #1;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL ack_timeout_a: no ack within %0d cycles", limit); end
  endtask

  task automatic wait_ack_b(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ib.ack != 0) begin ok = 1'b1; break; end
    end
    #1;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL ack_timeout_b: no ack within %0d cycles", limit); end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ia.req = '0; ia.req_data = '0; ia.req_len = '0;
    ib.req = '0; ib.req_data = '0; ib.req_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({ia.ack, ia.grant_id, ia.busy, ia.tx_sdata, ia.tx_start} !== 13'h0) begin
      mismatched++; $display("FAIL reset_a: got ack=%b grant=%0d busy=%b sdata=%h start=%b want all 0",
        ia.ack, ia.grant_id, ia.busy, ia.tx_sdata, ia.tx_start);
    end
    compared++;
    if ({ib.ack, ib.grant_id, ib.busy, ib.tx_sdata, ib.tx_start} !== 15'h0) begin
      mismatched++; $display("FAIL reset_b: got ack=%b grant=%0d busy=%b sdata=%h start=%b want all 0",
        ib.ack, ib.grant_id, ib.busy, ib.tx_sdata, ib.tx_start);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({ia.busy, ia.tx_start, ib.busy, ib.tx_start} !== 4'b0) begin
      mismatched++; $display("FAIL idle_after_reset: got busy_a=%b start_a=%b busy_b=%b start_b=%b want 0",
        ia.busy, ia.tx_start, ib.busy, ib.tx_start);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp[4];
    int req_cyc;
    bit ok;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_a();
    @(negedge clk);
    ia.req_data = {32'h0, 32'h44332211};
    ia.req_len  = {2'd0, 2'd3};
    ia.req      = 2'b01;
    req_cyc     = cyc + 1;
    repeat (3) @(negedge clk);
    compared++;
    if (ia.busy !== 1'b1 || ia.grant_id !== 1'b0) begin
      mismatched++; $display("FAIL single_owner: got busy=%b grant=%0d want busy=1 grant=0", ia.busy, ia.grant_id);
    end
    wait_ack_a(400, ok);
    ia.req = 2'b00;
    compared++;
    if (starts_a.size() !== 4) begin
      mismatched++; $display("FAIL single_nstart: got %0d want 4", starts_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < bytes_a.size()) begin
        compared++;
        if (bytes_a[i] !== exp[i]) begin
          mismatched++; $display("FAIL single_byte%0d: got %h want %h", i, bytes_a[i], exp[i]);
        end
      end
    end
    compared++;
    if (width_err_a !== 0) begin
      mismatched++; $display("FAIL single_start_width: got %0d multi-cycle pulses want 0", width_err_a);
    end
    compared++;
    if (ack_cnt_a[0] !== 1 || ack_cnt_a[1] !== 0) begin
      mismatched++; $display("FAIL single_ack_count: got ack0=%0d ack1=%0d want 1/0", ack_cnt_a[0], ack_cnt_a[1]);
    end
    if (starts_a.size() > 0) begin
      compared++;
      if (starts_a[0] !== req_cyc) begin
        mismatched++; $display("FAIL single_start_latency: got cycle %0d want %0d", starts_a[0], req_cyc);
      end
    end
    compared++;
    if (ack_cyc_a !== fall_at_ack_a + 1) begin
      mismatched++; $display("FAIL single_ack_latency: got cycle %0d want %0d", ack_cyc_a, fall_at_ack_a + 1);
    end
    @(negedge clk);
    compared++;
    if (ia.busy !== 1'b0) begin
      mismatched++; $display("FAIL single_busy_after: got %b want 0", ia.busy);
    end
  endtask

  task automatic test_len0();
    bit ok;
    clear_a();
    @(negedge clk);
    ia.req_data = {32'hDEADBEEF, 32'h0};
    ia.req_len  = {2'd0, 2'd0};
    ia.req      = 2'b10;
    wait_ack_a(200, ok);
    ia.req = 2'b00;
    repeat (30) @(negedge clk);
    #1;
    compared++;
    if (starts_a.size() !== 1) begin
      mismatched++; $display("FAIL len0_nstart: got %0d want 1", starts_a.size());
    end
    if (bytes_a.size() > 0) begin
      compared++;
      if (bytes_a[0] !== 8'hEF) begin
        mismatched++; $display("FAIL len0_byte: got %h want ef", bytes_a[0]);
      end
    end
    compared++;
    if (last_ack_a !== 2'b10 || ack_cnt_a[1] !== 1) begin
      mismatched++; $display("FAIL len0_ack: got ack=%b count=%0d want 10/1", last_ack_a, ack_cnt_a[1]);
    end
  endtask

  task automatic test_data_change();
    logic [7:0] exp[4];
    bit ok;
    exp = '{8'h21, 8'h43, 8'h65, 8'h87};
    clear_a();
    @(negedge clk);
    ia.req_data = {32'h0, 32'h87654321};
    ia.req_len  = {2'd0, 2'd3};
    ia.req      = 2'b01;
    for (int i = 0; i < 50 && starts_a.size() == 0; i++) begin
      @(negedge clk);
      #1;
    end
    ia.req_data = '1;
    ia.req_len  = '0;
    wait_ack_a(400, ok);
    ia.req = 2'b00;
    compared++;
    if (bytes_a.size() !== 4) begin
      mismatched++; $display("FAIL chg_nbytes: got %0d want 4", bytes_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < bytes_a.size()) begin
        compared++;
        if (bytes_a[i] !== exp[i]) begin
          mismatched++; $display("FAIL chg_byte%0d: got %h want %h", i, bytes_a[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_line_busy();
    int rel_cyc;
    bit ok;
    clear_a();
    @(negedge clk);
    ext_busy_a  = 1'b1;
    ia.req_data = {32'h0, 32'h0000005A};
    ia.req_len  = '0;
    ia.req      = 2'b01;
    repeat (15) @(negedge clk);
    #1;
    compared++;
    if (starts_a.size() !== 0) begin
      mismatched++; $display("FAIL busy_hold: got %0d starts want 0", starts_a.size());
    end
    ext_busy_a = 1'b0;
    rel_cyc = cyc;
    wait_ack_a(200, ok);
    ia.req = 2'b00;
    compared++;
    if (bytes_a.size() !== 1) begin
      mismatched++; $display("FAIL busy_nbytes: got %0d want 1", bytes_a.size());
    end else begin
      compared++;
      if (bytes_a[0] !== 8'h5A || starts_a[0] !== rel_cyc + 1) begin
        mismatched++; $display("FAIL busy_release: got byte %h at %0d want 5a at %0d",
          bytes_a[0], starts_a[0], rel_cyc + 1);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_order[7];
    logic [7:0] exp_byte;
    bit ok;
    exp_order = '{0, 1, 2, 0, 1, 2, 0};
    @(negedge clk);
    ib.req_data = {32'h000000C2, 32'h000000B1, 32'h000000A0};
    ib.req_len  = '0;
    ib.req      = 3'b111;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) ib.req = 3'b001;
      if (i == 4) ib.req = 3'b010;
      if (i == 5) ib.req = 3'b101;
      wait_ack_b(200, ok);
      if (!ok) begin
        ib.req = '0;
        continue;
      end
      compared++;
      if (last_ack_b !== (3'b001 << exp_order[i]) || grant_at_ack_b !== 2'(exp_order[i])) begin
        mismatched++; $display("FAIL rr_order%0d: got ack=%b grant=%0d want requester %0d",
          i, last_ack_b, grant_at_ack_b, exp_order[i]);
      end
      exp_byte = 8'hA0 + 8'(8'h11 * exp_order[i]);
      if (bytes_b.size() > 0) begin
        compared++;
        if (bytes_b[bytes_b.size()-1] !== exp_byte) begin
          mismatched++; $display("FAIL rr_byte%0d: got %h want %h", i, bytes_b[bytes_b.size()-1], exp_byte);
        end
      end
      ib.req = ib.req & ~last_ack_b;
    end
    compared++;
    if (bytes_b.size() !== 7) begin
      mismatched++; $display("FAIL rr_nbytes: got %0d want 7", bytes_b.size());
    end
  endtask

  task automatic test_reset_mid();
    int acks_before;
    bit ok;
    clear_a();
    @(negedge clk);
    ia.req_data = {32'h44332211, 32'h0};
    ia.req_len  = {2'd3, 2'd0};
    ia.req      = 2'b10;
    for (int i = 0; i < 200 && starts_a.size() < 2; i++) begin
      @(negedge clk);
      #1;
    end
    compared++;
    if (starts_a.size() !== 2) begin
      mismatched++; $display("FAIL rstmid_progress: got %0d starts want 2", starts_a.size());
    end
    repeat (5) @(negedge clk);
    acks_before = ack_cnt_a[1];
    rstn = 1'b0;
    ia.req = 2'b00;
    @(negedge clk);
    compared++;
    if ({ia.ack, ia.grant_id, ia.busy, ia.tx_sdata, ia.tx_start} !== 13'h0) begin
      mismatched++; $display("FAIL rstmid_outputs: got ack=%b grant=%0d busy=%b sdata=%h start=%b want all 0",
        ia.ack, ia.grant_id, ia.busy, ia.tx_sdata, ia.tx_start);
    end
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    compared++;
    if (ack_cnt_a[1] !== acks_before || starts_a.size() !== 2) begin
      mismatched++; $display("FAIL rstmid_no_ack: got acks=%0d starts=%0d want %0d/2",
        ack_cnt_a[1], starts_a.size(), acks_before);
    end
    clear_a();
    ia.req_len = {2'd1, 2'd0};
    ia.req     = 2'b10;
    wait_ack_a(200, ok);
    ia.req = 2'b00;
    compared++;
    if (bytes_a.size() !== 2) begin
      mismatched++; $display("FAIL rstmid_fresh_n: got %0d bytes want 2", bytes_a.size());
    end else begin
      compared++;
      if (bytes_a[0] !== 8'h11 || bytes_a[1] !== 8'h22) begin
        mismatched++; $display("FAIL rstmid_fresh_bytes: got %h %h want 11 22", bytes_a[0], bytes_a[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_len0();
    test_data_change();
    test_line_busy();
    test_round_robin();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
